pdm_sample_interp: RTL
======================

# pdm_sample_interp

Upstream feeder for the second-order sigma-delta PDM DAC. It accepts signed PCM samples over a valid/ready handshake and buffers them in a small FIFO. It generates the DAC's clock-enable strobe and upsamples each sample by a power-of-two oversampling ratio using linear interpolation, producing the `o_func`/`o_ce` pair that drives the DAC's `i_func`/`i_ce` inputs directly.

## Interface
- `WIDTH`, 8: sample width, signed two's complement; must equal the DAC's `INPUT_WIDTH`.
- `LOG2_OSR`, 6: log2 of interpolation steps per input sample (OSR = 2**LOG2_OSR); must be ≥1.
- `CE_DIV`, 4: `i_clk` cycles per `o_ce` pulse; must be ≥1.
- `FIFO_AW`, 2: log2 of FIFO depth.

Ports (name, direction, width, meaning):
- `i_clk` in 1: clock.
- `i_res_n` in 1: reset, asynchronous, active-low.
- `i_sample` in WIDTH: input sample.
- `i_valid` in 1: `i_sample` valid.
- `o_ready` out 1: FIFO can accept a sample.
- `i_clr_underrun` in 1: clears the sticky underrun flag.
- `o_func` out WIDTH: interpolated sample to the DAC.
- `o_ce` out 1: one-cycle DAC step strobe.
- `o_underrun` out 1: sticky underrun flag.
- `o_level` out FIFO_AW+1: FIFO occupancy.

## Operation
- Reset (async assert, sync release): counters, phase, `prev`, `cur`, `o_func`, `o_ce`, `o_underrun` and `o_level` all go to 0. `o_ready` goes to 1. FIFO contents are discarded, including when reset is asserted mid-operation.

**CE divider**
- Counter runs 0..CE_DIV-1.
- `o_ce` is registered and high for exactly one cycle when the counter wraps.
- With CE_DIV=1, `o_ce` is constantly high after reset.

**FIFO**
- Depth is 2**FIFO_AW.
- `o_ready` = !full.
- A push occurs on a cycle with `i_valid && o_ready`.
- A push and a pop in the same cycle leave `o_level` unchanged.
- There is no bypass: a pop on an empty FIFO underruns even if a push happens in the same cycle.

**Step** (on each `o_ce` cycle, with phase counter `ph` of LOG2_OSR bits)
- If `ph == OSR-1` (boundary):
  - `ph` ← 0, `prev` ← `cur`, `o_func` ← `cur`.
  - If the FIFO is non-empty, `cur` ← FIFO head (pop).
  - Otherwise `cur` is unchanged and `o_underrun` ← 1.
- Otherwise:
  - `ph` ← `ph+1`.
  - `o_func` ← `prev + ((cur − prev) * (ph+1)) >>> LOG2_OSR`.

**Arithmetic**
- Delta is WIDTH+1 bits signed.
- Product is WIDTH+1+LOG2_OSR bits signed.
- The shift is arithmetic (floor).
- The result always lies between `prev` and `cur` and is truncated to WIDTH bits with no overflow.

**Underrun flag**
- `o_underrun` is cleared by `i_clr_underrun`.
- If set and clear occur in the same cycle, set wins.

## Timing
- `o_func` updates on the clock edge ending an `o_ce` cycle, then holds for CE_DIV cycles. It is therefore stable whenever `o_ce` is high, and the DAC consumes the value computed at the previous step.
- A sample popped at a boundary becomes `cur`. It appears fully on `o_func` at the next boundary, OSR steps later.
- Minimum latency from push into an empty FIFO to first influence on `o_func`: up to OSR·CE_DIV cycles to the next boundary, plus 1 step.
- `o_ready` is combinational from the FIFO count. It deasserts the cycle after the push that fills the FIFO, and reasserts the cycle after a pop from full.

## Configuration
- `PDM_INTERP_LINEAR_EN` defined: linear interpolation exactly as described under Operation.
- Not defined: zero-order hold.
  - Every step sets `o_func` ← `prev` (value after the boundary update).
  - No multiplier is instantiated.
  - Phase, FIFO, underrun and latency behaviour are identical.

## Test plan
Bench parameters: WIDTH=8, LOG2_OSR=2, CE_DIV=4, FIFO_AW=2, macro defined unless stated.
1. Hold `i_res_n` low, then release → `o_func`=0, `o_ce`=0, `o_ready`=1, `o_level`=0, `o_underrun`=0. Assert reset mid-stream → same values immediately, without waiting for a clock edge.
2. Free run → `o_ce` one cycle high every 4 cycles. With an empty FIFO, `o_underrun` rises at the 4th step, and `i_clr_underrun` clears it.
3. Push 0 then 64 → after `cur` becomes 64 (with `prev`=0), successive steps give `o_func` = 16, 32, 48, 64.
4. Negative slope, `prev`=64 and `cur`=−64 (0xC0) → steps give 32, 0, −32 (0xE0), −64 (0xC0). This checks the 9-bit delta and arithmetic shift.
5. Push 5 back-to-back samples with pops stalled → `o_level`=4 and `o_ready`=0 after the 4th push. The 5th sample is accepted only on the cycle after the next boundary pop. All samples emerge in order.
6. Macro undefined, stimulus as in test 3 → `o_func` stays 0 for 3 steps, then 64. No intermediate values appear.

Source files
------------

// File: rtl/pdm_sample_interp.sv
// PCM-to-PDM feeder: sample FIFO, DAC clock-enable divider and power-of-two upsampler.
// Define PDM_INTERP_LINEAR_EN for linear interpolation; otherwise each sample is held (zero-order hold).
module pdm_sample_interp #(
  parameter int WIDTH    = 8,
  parameter int LOG2_OSR = 6,
  parameter int CE_DIV   = 4,
  parameter int FIFO_AW  = 2
) (
  input  logic               i_clk,
  input  logic               i_res_n,
  input  logic [WIDTH-1:0]   i_sample,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_clr_underrun,
  output logic [WIDTH-1:0]   o_func,
  output logic               o_ce,
  output logic               o_underrun,
  output logic [FIFO_AW:0]   o_level
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int PW    = WIDTH + 1 + LOG2_OSR;

  localparam logic [CW-1:0]       CNT_LAST = CW'(CE_DIV - 1);
  localparam logic [LOG2_OSR-1:0] PH_LAST  = '1;
  localparam logic [FIFO_AW:0]    FULL_LVL = (FIFO_AW + 1)'(DEPTH);

  logic [CW-1:0]       ce_cnt;
  logic [LOG2_OSR-1:0] ph;
  logic [LOG2_OSR-1:0] ph_inc;
  logic [WIDTH-1:0]    prev;
  logic [WIDTH-1:0]    cur;
  logic [WIDTH-1:0]    step_val;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [FIFO_AW:0]    count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                boundary;

  // CE divider: registered strobe, high on the cycle after the counter wraps
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      ce_cnt <= '0;
      o_ce   <= 1'b0;
    end else if (ce_cnt == CNT_LAST) begin
      ce_cnt <= '0;
      o_ce   <= 1'b1;
    end else begin
      ce_cnt <= ce_cnt + CW'(1);
      o_ce   <= 1'b0;
    end
  end

  assign full     = (count == FULL_LVL);
  assign empty    = (count == '0);
  assign o_ready  = !full;
  assign o_level  = count;
  assign push     = i_valid && !full;
  assign boundary = (ph == PH_LAST);
  // No bypass: emptiness is judged on the pre-edge count, so a same-cycle push cannot feed the pop
  assign pop      = o_ce && boundary && !empty;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_sample;
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign ph_inc = ph + LOG2_OSR'(1);

`ifdef PDM_INTERP_LINEAR_EN
  logic signed [WIDTH:0]    delta;
  logic signed [LOG2_OSR:0] weight;
  logic signed [PW-1:0]     prod;

  // Result lies between prev and cur, so keeping the low WIDTH bits of the sum is exact
  always_comb begin
    delta    = $signed({cur[WIDTH-1], cur}) - $signed({prev[WIDTH-1], prev});
    weight   = $signed({1'b0, ph_inc});
    prod     = PW'(delta) * PW'(weight);
    step_val = WIDTH'(PW'($signed(prev)) + (prod >>> LOG2_OSR));
  end
`else
  assign step_val = prev;
`endif

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      ph     <= '0;
      prev   <= '0;
      cur    <= '0;
      o_func <= '0;
    end else if (o_ce) begin
      if (boundary) begin
        ph     <= '0;
        prev   <= cur;
        o_func <= cur;
        if (!empty) cur <= mem[rd_ptr];
      end else begin
        ph     <= ph_inc;
        o_func <= step_val;
      end
    end
  end

  // Set on a starved boundary takes priority over a same-cycle clear
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      o_underrun <= 1'b0;
    end else if (o_ce && boundary && empty) begin
      o_underrun <= 1'b1;
    end else if (i_clr_underrun) begin
      o_underrun <= 1'b0;
    end
  end

endmodule
